// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: execute opcodes, MEM-stage state encoding and the
// word retired on a data-memory timeout.
package pipe_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1110;
  localparam logic [3:0] OP_MOV   = 4'b1111;

  localparam logic [15:0] DEAD_WORD = 16'hDEAD;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the MEM stage; tc flags the last cycle a request may
// remain unacknowledged before it is aborted.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The cycle that would bring the count up to LIMIT is the abort cycle.
  assign tc = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, data-memory req/ack sequencing with timeout,
// and writeback outputs. Define MEM_FWD_EN to add the forwarding/interlock outputs.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_control,
  input  logic [15:0]       ex_result,
  input  logic [15:0]       ex_store_data,
  input  logic [5:0]        ex_dest,
  input  logic              ex_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [15:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [15:0]       wb_data,
  output logic [5:0]        wb_dest,
  output logic              wb_we,
  output logic              mem_err
`ifdef MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [5:0]        fwd_dest,
  output logic [15:0]       fwd_data,
  output logic              load_pending
`endif
);

  mem_state_e        state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [15:0]       dmem_wdata_q, dmem_wdata_d;
  logic [5:0]        dest_q, dest_d;
  logic              wb_valid_q, wb_valid_d;
  logic [15:0]       wb_data_q, wb_data_d;
  logic [5:0]        wb_dest_q, wb_dest_d;
  logic              wb_we_q, wb_we_d;
  logic              mem_err_q, mem_err_d;

  logic [3:0]  op;
  logic        accept;
  logic        ctr_clr, ctr_en, ctr_tc;
  logic [15:0] addr_word;
  logic        ctrl_unused;

  assign op          = ex_control[3:0];
  assign ctrl_unused = ex_control[4];
  assign ex_ready    = (state_q == IDLE);
  assign accept      = ex_valid && ex_ready;

  assign ctr_clr = (state_q == IDLE);
  assign ctr_en  = (state_q == MEM_WAIT) && !dmem_ack;

  mem_timeout_ctr #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  // STORE retires its address, zero-extended to the datapath width.
  always_comb begin
    addr_word             = '0;
    addr_word[ADDR_W-1:0] = dmem_addr_q;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dest_d       = dest_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_dest_d    = wb_dest_q;
    wb_we_d      = wb_we_q;
    mem_err_d    = mem_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem_op(op)) begin
            state_d      = MEM_WAIT;
            dmem_req_d   = 1'b1;
            dmem_we_d    = (op == OP_STORE);
            dmem_addr_d  = ex_result[ADDR_W-1:0];
            dmem_wdata_d = ex_store_data;
            dest_d       = ex_dest;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_result;
            wb_dest_d  = ex_dest;
            wb_we_d    = (op == OP_NOP) ? 1'b0 : ex_we;
          end
        end
      end

      MEM_WAIT: begin
        // Ack is checked before the terminal count so a last-cycle ack still completes.
        if (dmem_ack) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_dest_d  = dest_q;
          if (dmem_we_q) begin
            wb_data_d = addr_word;
            wb_we_d   = 1'b0;
          end else begin
            wb_data_d = dmem_rdata;
            wb_we_d   = 1'b1;
          end
        end else if (ctr_tc) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          mem_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = DEAD_WORD;
          wb_dest_d  = dest_q;
          wb_we_d    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dest_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      wb_we_q      <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dest_q       <= dest_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_dest_q    <= wb_dest_d;
      wb_we_q      <= wb_we_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_dest    = wb_dest_q;
  assign wb_we      = wb_we_q;
  assign mem_err    = mem_err_q;

`ifdef MEM_FWD_EN
  // While a LOAD waits, decode sees its destination to interlock on.
  assign load_pending = (state_q == MEM_WAIT) && !dmem_we_q;
  assign fwd_valid    = (state_q == IDLE) && wb_valid_q && wb_we_q;
  assign fwd_dest     = load_pending ? dest_q : wb_dest_q;
  assign fwd_data     = wb_data_q;
`endif

endmodule
